level_flow_controller: RTL and testbench

Top-level game sequencer that drives the level generator through its generate/finish handshake. It runs the per-level round timer, computes the level's target score from the generated level value, and decides win/shop/game-over/victory. It sits between the input/timing logic (start button, 1 Hz tick, shop) and the level generator plus the object and score datapath.

---
 rtl/level_flow_controller.sv | 195 +++++++++++++++++++
 tb/tb_level_flow_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/level_flow_controller.sv
// Game-level sequencer. It handshakes with the level generator, runs the round timer,
// derives the target score for each level and resolves win, shop, game-over and victory.
module level_flow_controller #(
    parameter int unsigned ROUND_SECONDS = 60,
    parameter int unsigned MAX_LEVEL     = 15,
    parameter int unsigned MIN_TARGET    = 100,
    parameter int unsigned GEN_TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startGame,
    input  logic        secondTick,
    input  logic        pauseN,
    input  logic        finishedGenerating,
    input  logic [19:0] levelValue,
    input  logic [19:0] levelScore,
    input  logic        allCollected,
    input  logic        shopDone,
    output logic        generateNewLevel,
    output logic [3:0]  levelIndex,
    output logic [19:0] targetScore,
    output logic [6:0]  timeLeft,
    output logic [2:0]  gameState,
    output logic        playEnable,
    output logic        levelWon
);

    localparam int unsigned VAL_W   = 20;
    localparam int unsigned LVL_W   = 4;
    localparam int unsigned TIME_W  = 7;
    localparam int unsigned GS_W    = 3;
    localparam int unsigned CNT_W   = $clog2(GEN_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_GEN_PULSE,
        S_GEN_SETTLE,
        S_GEN_WAIT,
        S_PLAY,
        S_EVAL,
        S_SHOP,
        S_GAME_OVER,
        S_VICTORY
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_gen_cnt;
    logic [CNT_W-1:0]   w_gen_cnt_nxt;
    logic               r_generate;
    logic               w_generate_nxt;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [VAL_W-1:0]   r_target;
    logic [VAL_W-1:0]   w_target_nxt;
    logic [TIME_W-1:0]  r_time;
    logic [TIME_W-1:0]  w_time_nxt;
    logic [GS_W-1:0]    r_game_state;
    logic [GS_W-1:0]    w_game_state_nxt;
    logic               r_play_en;
    logic               w_play_en_nxt;
    logic               r_level_won;
    logic               w_level_won_nxt;
    logic [VAL_W-1:0]   w_target_raw;
    logic [VAL_W-1:0]   w_target_calc;

    // Target is 3/4 of the level value, floored at MIN_TARGET.
    assign w_target_raw  = (levelValue >> 1) + (levelValue >> 2);
    assign w_target_calc = (w_target_raw < VAL_W'(MIN_TARGET)) ? VAL_W'(MIN_TARGET) : w_target_raw;

    // The three GEN phases all report the same external state code.
    function automatic logic [GS_W-1:0] encode_state(input state_t s);
        logic [GS_W-1:0] code;
        code = GS_W'(0);
        case (s)
            S_IDLE:       code = GS_W'(0);
            S_GEN_PULSE,
            S_GEN_SETTLE,
            S_GEN_WAIT:   code = GS_W'(1);
            S_PLAY:       code = GS_W'(2);
            S_EVAL:       code = GS_W'(3);
            S_SHOP:       code = GS_W'(4);
            S_GAME_OVER:  code = GS_W'(5);
            S_VICTORY:    code = GS_W'(6);
            default:      code = GS_W'(0);
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_gen_cnt    <= '0;
            r_generate   <= 1'b0;
            r_level      <= '0;
            r_target     <= '0;
            r_time       <= '0;
            r_game_state <= '0;
            r_play_en    <= 1'b0;
            r_level_won  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gen_cnt    <= w_gen_cnt_nxt;
            r_generate   <= w_generate_nxt;
            r_level      <= w_level_nxt;
            r_target     <= w_target_nxt;
            r_time       <= w_time_nxt;
            r_game_state <= w_game_state_nxt;
            r_play_en    <= w_play_en_nxt;
            r_level_won  <= w_level_won_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gen_cnt_nxt   = r_gen_cnt;
        w_generate_nxt  = 1'b0;
        w_level_nxt     = r_level;
        w_target_nxt    = r_target;
        w_time_nxt      = r_time;
        w_level_won_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_GAME_OVER, S_VICTORY: begin
                if (startGame) begin
                    w_level_nxt    = '0;
                    w_generate_nxt = 1'b1;
                    w_state_nxt    = S_GEN_PULSE;
                end
            end
            S_GEN_PULSE: begin
                w_gen_cnt_nxt = '0;
                w_state_nxt   = S_GEN_SETTLE;
            end
            // The generator's done flag may still show the previous level here.
            S_GEN_SETTLE: begin
                w_state_nxt = S_GEN_WAIT;
            end
            S_GEN_WAIT: begin
                if (finishedGenerating) begin
                    w_target_nxt  = w_target_calc;
                    w_time_nxt    = TIME_W'(ROUND_SECONDS);
                    w_gen_cnt_nxt = '0;
                    w_state_nxt   = S_PLAY;
                end else if (r_gen_cnt == CNT_W'(GEN_TIMEOUT - 1)) begin
                    w_gen_cnt_nxt  = '0;
                    w_generate_nxt = 1'b1;
                    w_state_nxt    = S_GEN_PULSE;
                end else begin
                    w_gen_cnt_nxt = r_gen_cnt + CNT_W'(1);
                end
            end
            // allCollected takes priority over a coincident tick.
            S_PLAY: begin
                if (allCollected || (r_time == '0)) begin
                    w_state_nxt = S_EVAL;
                end else if (secondTick && pauseN) begin
                    w_time_nxt = r_time - TIME_W'(1);
                end
            end
            S_EVAL: begin
                if (levelScore >= r_target) begin
                    w_level_won_nxt = 1'b1;
                    w_state_nxt     = (r_level == LVL_W'(MAX_LEVEL)) ? S_VICTORY : S_SHOP;
                end else begin
                    w_state_nxt = S_GAME_OVER;
                end
            end
            S_SHOP: begin
                if (shopDone) begin
                    if (r_level < LVL_W'(MAX_LEVEL)) begin
                        w_level_nxt = r_level + LVL_W'(1);
                    end
                    w_generate_nxt = 1'b1;
                    w_state_nxt    = S_GEN_PULSE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_game_state_nxt = encode_state(w_state_nxt);
        w_play_en_nxt    = (w_state_nxt == S_PLAY);
    end

    assign generateNewLevel = r_generate;
    assign levelIndex       = r_level;
    assign targetScore      = r_target;
    assign timeLeft         = r_time;
    assign gameState        = r_game_state;
    assign playEnable       = r_play_en;
    assign levelWon         = r_level_won;

endmodule

// File: tb/tb_level_flow_controller.sv
// Directed bench for level_flow_controller: generate handshake, timer, evaluation,
// shop progression, victory, generation timeout and asynchronous reset.
module tb_level_flow_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startGame;
    logic        secondTick;
    logic        pauseN;
    logic        finishedGenerating;
    logic [19:0] levelValue;
    logic [19:0] levelScore;
    logic        allCollected;
    logic        shopDone;
    logic        generateNewLevel;
    logic [3:0]  levelIndex;
    logic [19:0] targetScore;
    logic [6:0]  timeLeft;
    logic [2:0]  gameState;
    logic        playEnable;
    logic        levelWon;

    int checks   = 0;
    int failures = 0;
    int gen_pulses = 0;

    level_flow_controller dut (
        .clk                (clk),
        .resetN             (resetN),
        .startGame          (startGame),
        .secondTick         (secondTick),
        .pauseN             (pauseN),
        .finishedGenerating (finishedGenerating),
        .levelValue         (levelValue),
        .levelScore         (levelScore),
        .allCollected       (allCollected),
        .shopDone           (shopDone),
        .generateNewLevel   (generateNewLevel),
        .levelIndex         (levelIndex),
        .targetScore        (targetScore),
        .timeLeft           (timeLeft),
        .gameState          (gameState),
        .playEnable         (playEnable),
        .levelWon           (levelWon)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (generateNewLevel) gen_pulses <= gen_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_second();
        secondTick = 1'b1;
        step();
        secondTick = 1'b0;
        step();
    endtask

    initial begin
        resetN = 1'b0;
        startGame = 1'b0;
        secondTick = 1'b0;
        pauseN = 1'b1;
        finishedGenerating = 1'b0;
        levelValue = '0;
        levelScore = '0;
        allCollected = 1'b0;
        shopDone = 1'b0;

        repeat (2) step();
        check_eq("rst_state", 32'(gameState), 0);
        check_eq("rst_gen", 32'(generateNewLevel), 0);
        check_eq("rst_level", 32'(levelIndex), 0);
        check_eq("rst_target", 32'(targetScore), 0);
        check_eq("rst_time", 32'(timeLeft), 0);
        check_eq("rst_play", 32'(playEnable), 0);
        check_eq("rst_won", 32'(levelWon), 0);
        resetN = 1'b1;
        step();
        check_eq("idle_hold", 32'(gameState), 0);

        // Start; generator finishes in the third WAIT cycle with value 1000
        startGame = 1'b1;
        step();
        startGame = 1'b0;
        check_eq("start_state", 32'(gameState), 1);
        check_eq("start_gen", 32'(generateNewLevel), 1);
        check_eq("start_level", 32'(levelIndex), 0);
        step();
        check_eq("settle_gen", 32'(generateNewLevel), 0);
        step();
        step();
        step();
        check_eq("wait3_state", 32'(gameState), 1);
        finishedGenerating = 1'b1;
        levelValue = 20'd1000;
        step();
        check_eq("play_state", 32'(gameState), 2);
        check_eq("play_en", 32'(playEnable), 1);
        check_eq("play_target", 32'(targetScore), 750);
        check_eq("play_time", 32'(timeLeft), 60);
        check_eq("gen_once", 32'(gen_pulses), 1);

        // Run timer to 10, then allCollected and tick together
        for (int i = 0; i < 50; i++) tick_second();
        check_eq("time_10", 32'(timeLeft), 10);
        allCollected = 1'b1;
        secondTick = 1'b1;
        step();
        allCollected = 1'b0;
        secondTick = 1'b0;
        levelScore = 20'd800;
        check_eq("eval_state", 32'(gameState), 3);
        check_eq("eval_time_kept", 32'(timeLeft), 10);
        check_eq("eval_play_off", 32'(playEnable), 0);
        step();
        check_eq("shop_state", 32'(gameState), 4);
        check_eq("won_pulse", 32'(levelWon), 1);
        step();
        check_eq("won_clear", 32'(levelWon), 0);
        check_eq("shop_hold", 32'(gameState), 4);
        shopDone = 1'b1;
        step();
        shopDone = 1'b0;
        check_eq("shop_exit_state", 32'(gameState), 1);
        check_eq("shop_exit_level", 32'(levelIndex), 1);
        check_eq("shop_exit_gen", 32'(generateNewLevel), 1);

        // Stale finishedGenerating held through PULSE/SETTLE must be ignored
        step();
        check_eq("stale_settle", 32'(gameState), 1);
        step();
        check_eq("stale_wait1", 32'(gameState), 1);
        finishedGenerating = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stale_wait", 32'(gameState), 1);
        end
        finishedGenerating = 1'b1;
        step();
        check_eq("stale_play", 32'(gameState), 2);
        check_eq("stale_target", 32'(targetScore), 750);
        check_eq("stale_time", 32'(timeLeft), 60);

        // 65 ticks, first 5 paused; then lose with 749 against 750
        for (int i = 0; i < 64; i++) begin
            pauseN = (i >= 5);
            tick_second();
        end
        pauseN = 1'b1;
        check_eq("pause_time1", 32'(timeLeft), 1);
        check_eq("pause_state", 32'(gameState), 2);
        levelScore = 20'd749;
        secondTick = 1'b1;
        step();
        secondTick = 1'b0;
        check_eq("time_zero", 32'(timeLeft), 0);
        check_eq("zero_still_play", 32'(gameState), 2);
        step();
        check_eq("lose_eval", 32'(gameState), 3);
        step();
        check_eq("gameover_state", 32'(gameState), 5);
        check_eq("gameover_nowon", 32'(levelWon), 0);
        check_eq("gameover_level", 32'(levelIndex), 1);
        check_eq("gameover_target", 32'(targetScore), 750);

        // Generator never finishes: re-pulse every GEN_TIMEOUT+2 cycles
        finishedGenerating = 1'b0;
        startGame = 1'b1;
        step();
        startGame = 1'b0;
        check_eq("restart_state", 32'(gameState), 1);
        check_eq("restart_level", 32'(levelIndex), 0);
        check_eq("restart_gen", 32'(generateNewLevel), 1);
        repeat (1024) step();
        check_eq("to_before_gen", 32'(generateNewLevel), 0);
        check_eq("to_before_state", 32'(gameState), 1);
        step();
        check_eq("to_regen", 32'(generateNewLevel), 1);
        check_eq("to_state", 32'(gameState), 1);
        step();
        step();
        finishedGenerating = 1'b1;
        levelValue = 20'd40;
        step();
        check_eq("floor_state", 32'(gameState), 2);
        check_eq("floor_target", 32'(targetScore), 100);

        // Win through to level 15, then victory
        levelScore = 20'hFFFFF;
        for (int i = 1; i <= 15; i++) begin
            allCollected = 1'b1;
            step();
            step();
            shopDone = 1'b1;
            step();
            shopDone = 1'b0;
            step();
            step();
            step();
            check_eq("climb_level", 32'(levelIndex), 32'(i));
        end
        check_eq("lvl15_play", 32'(gameState), 2);
        step();
        step();
        check_eq("victory_state", 32'(gameState), 6);
        check_eq("victory_level", 32'(levelIndex), 15);
        check_eq("victory_won", 32'(levelWon), 1);
        step();
        check_eq("victory_hold", 32'(gameState), 6);
        check_eq("victory_level_hold", 32'(levelIndex), 15);

        // Reset in the middle of GEN WAIT
        allCollected = 1'b0;
        startGame = 1'b1;
        step();
        startGame = 1'b0;
        check_eq("v_restart_level", 32'(levelIndex), 0);
        finishedGenerating = 1'b0;
        step();
        step();
        step();
        check_eq("pre_rst_state", 32'(gameState), 1);
        resetN = 1'b0;
        #1;
        check_eq("arst_state", 32'(gameState), 0);
        check_eq("arst_target", 32'(targetScore), 0);
        check_eq("arst_time", 32'(timeLeft), 0);
        check_eq("arst_play", 32'(playEnable), 0);
        check_eq("arst_gen", 32'(generateNewLevel), 0);
        check_eq("arst_won", 32'(levelWon), 0);
        step();
        resetN = 1'b1;
        step();
        check_eq("post_rst_idle", 32'(gameState), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
